// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet TX buffer reader: default widths, FSM states and
// the byte-length to word-count helper.
package eth_tx_pkg;

  parameter int unsigned DEFAULT_ADDR_W = 11;
  parameter int unsigned DEFAULT_LEN_W  = 12;
  parameter int unsigned WORD_W         = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  // Number of 16-bit buffer words covering len bytes.
  function automatic int unsigned calc_words(input int unsigned len);
    return (len + 1) >> 1;
  endfunction

endpackage

// File: rtl/eth_tx_word_fifo.sv
// Two-entry word FIFO between the buffer read port and the byte serialiser.
module eth_tx_word_fifo
  import eth_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [1:0]        count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic [WORD_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/eth_tx_buf_reader.sv
// Drains a frame from the TX buffer 16-bit read port and streams it out byte-wise,
// low byte first, over an AXI-Stream master with backpressure.
module eth_tx_buf_reader
  import eth_tx_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned LEN_W      = DEFAULT_LEN_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_total_q, words_total_d;
  logic [LEN_W-1:0]  words_issued_q, words_issued_d;
  logic [LEN_W-1:0]  bytes_sent_q, bytes_sent_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic              byte_sel_q, byte_sel_d;
  logic              done_q, done_d;

  logic [15:0]       fifo_rdata;
  logic [1:0]        fifo_count;
  logic              fifo_full, fifo_empty;
  logic              issue, last_byte, hs, pop;

  eth_tx_word_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .wdata_i (mem_rdata_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // Reserve a FIFO slot for the read in flight so returned data always has room.
    issue = (state_q == StRun) && (words_issued_q < words_total_q) && !fifo_full &&
            (({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH));
    last_byte = (bytes_sent_q == (len_q - LEN_W'(1)));
    hs        = !fifo_empty && m_axis_tready;
    // Odd-length frames end on a low byte, so the final word is popped early.
    pop       = hs && (byte_sel_q || last_byte);
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    words_total_d  = words_total_q;
    words_issued_d = words_issued_q;
    bytes_sent_d   = bytes_sent_q;
    rd_ptr_d       = rd_ptr_q;
    byte_sel_d     = byte_sel_q;
    done_d         = 1'b0;
    // Read data always lands the cycle after issue, so the flag simply tracks issue.
    inflight_d     = issue;

    if (hs) begin
      bytes_sent_d = bytes_sent_q + LEN_W'(1);
      byte_sel_d   = !pop;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_d          = len_i;
            words_total_d  = LEN_W'(calc_words(32'(len_i)));
            words_issued_d = '0;
            bytes_sent_d   = '0;
            rd_ptr_d       = '0;
            byte_sel_d     = 1'b0;
            state_d        = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          rd_ptr_d       = rd_ptr_q + ADDR_W'(1);
          words_issued_d = words_issued_q + LEN_W'(1);
          if ((words_issued_q + LEN_W'(1)) == words_total_q) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (hs && last_byte) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      words_total_q  <= '0;
      words_issued_q <= '0;
      bytes_sent_q   <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      byte_sel_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      words_total_q  <= words_total_d;
      words_issued_q <= words_issued_d;
      bytes_sent_q   <= bytes_sent_d;
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= inflight_d;
      byte_sel_q     <= byte_sel_d;
      done_q         <= done_d;
    end
  end

  assign mem_en_o      = issue;
  assign mem_addr_o    = rd_ptr_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = byte_sel_q ? fifo_rdata[15:8] : fifo_rdata[7:0];
  assign m_axis_tlast  = !fifo_empty && last_byte;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;

endmodule
